// File: rtl/counter_seq_ctrl_pkg.sv
// Shared encodings for the counter sequencer: command op codes and FSM state
// encodings. Imported by the sequencer RTL and by anything that drives or
// decodes its command/status ports (system control, testbench).
package counter_seq_ctrl_pkg;

    // icmd_op encodings
    localparam logic [1:0] OP_STOP     = 2'b00;
    localparam logic [1:0] OP_ONESHOT  = 2'b01;
    localparam logic [1:0] OP_PERIODIC = 2'b10;
    localparam logic [1:0] OP_PAUSE    = 2'b11;  // toggles RUN <-> PAUSED

    // ostate encodings; 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_core.sv
// counter_core: WIDTH-bit up-counter datapath owned by counter_seq_ctrl.
// Ports:
//   iclk  - clock, rising edge
//   irst  - asynchronous active-high reset, clears the count
//   ien   - increment enable
//   iclr  - synchronous clear, takes priority over ien
//   ocnt  - registered count
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ien,
    input  logic             iclr,
    output logic [WIDTH-1:0] ocnt
);

    always_ff @(posedge iclk or posedge irst) begin
        if (irst)
            ocnt <= '0;
        else if (iclr)
            ocnt <= '0;
        else if (ien)
            ocnt <= ocnt + 1'b1;
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for the up-counter datapath.
// Accepts STOP / ONESHOT / PERIODIC / PAUSE_TOGGLE over a valid/ready
// handshake and runs the counter against a programmable terminal value.
// Ports:
//   iclk, irst    - clock (rising edge), async active-high reset
//   icmd_valid    - command present
//   ocmd_ready    - command accepted this cycle if valid; low for one cycle
//                   after every accepted command
//   icmd_op       - command op code (see counter_seq_ctrl_pkg)
//   icmd_period   - terminal value P, sampled with ONESHOT/PERIODIC
//   ocnt          - current count
//   otc           - one-cycle terminal-count pulse
//   obusy         - high in RUN or PAUSED
//   oerr          - one-cycle pulse when a command is rejected
//   ostate        - FSM state encoding
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             icmd_valid,
    output logic             ocmd_ready,
    input  logic [1:0]       icmd_op,
    input  logic [WIDTH-1:0] icmd_period,
    output logic [WIDTH-1:0] ocnt,
    output logic             otc,
    output logic             obusy,
    output logic             oerr,
    output logic [1:0]       ostate
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] period_q;
    logic             periodic_q;

    logic accept, legal, tc_hit, cmd_taken;
    logic cnt_en, cnt_clr, tc_fire, err_fire, load;

    assign accept = icmd_valid & ocmd_ready;
    assign legal  = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_PAUSED);
    // Period is never 0 and the count is cleared on every load, so the count
    // can only reach period_q from below; no overflow path exists.
    assign tc_hit = (state == ST_RUN) && (ocnt == period_q);

    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        tc_fire   = 1'b0;
        err_fire  = 1'b0;
        load      = 1'b0;
        cmd_taken = 1'b0;

        if (!legal) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            if (accept) begin
                case (icmd_op)
                    OP_STOP: begin
                        state_nxt = ST_IDLE;
                        cnt_clr   = 1'b1;
                        cmd_taken = 1'b1;
                    end
                    OP_ONESHOT, OP_PERIODIC: begin
                        if (icmd_period == '0) begin
                            err_fire = 1'b1;
                        end else begin
                            state_nxt = ST_RUN;
                            cnt_clr   = 1'b1;
                            load      = 1'b1;
                            cmd_taken = 1'b1;
                        end
                    end
                    default: begin  // OP_PAUSE
                        case (state)
                            ST_RUN: begin
                                state_nxt = ST_PAUSED;
                                cmd_taken = 1'b1;
                            end
                            ST_PAUSED: begin
                                // count resumes on the following edge
                                state_nxt = ST_RUN;
                                cmd_taken = 1'b1;
                            end
                            default: err_fire = 1'b1;
                        endcase
                    end
                endcase
            end

            // A taken command owns this edge and suppresses the terminal
            // count; a rejected command has no effect, so counting proceeds.
            if (!cmd_taken && state == ST_RUN) begin
                if (tc_hit) begin
                    cnt_clr   = 1'b1;
                    tc_fire   = 1'b1;
                    state_nxt = periodic_q ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state      <= ST_IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            ocmd_ready <= 1'b0;
            otc        <= 1'b0;
            oerr       <= 1'b0;
            obusy      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ocmd_ready <= !accept;
            otc        <= tc_fire;
            oerr       <= err_fire;
            obusy      <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSED);
            if (load) begin
                period_q   <= icmd_period;
                periodic_q <= (icmd_op == OP_PERIODIC);
            end
        end
    end

    assign ostate = state;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .iclk (iclk),
        .irst (irst),
        .ien  (cnt_en),
        .iclr (cnt_clr),
        .ocnt (ocnt)
    );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl (WIDTH=4): a table of per-cycle
// {inputs, expected outputs} records plus hand-written multi-cycle sequences.
module tb_counter_seq_ctrl;
    import counter_seq_ctrl_pkg::*;

    logic       iclk, irst, icmd_valid, ocmd_ready;
    logic [1:0] icmd_op;
    logic [3:0] icmd_period, ocnt;
    logic       otc, obusy, oerr;
    logic [1:0] ostate;

    int n_vec = 0;
    int n_err = 0;

    counter_seq_ctrl #(.WIDTH(4)) dut (
        .iclk        (iclk),
        .irst        (irst),
        .icmd_valid  (icmd_valid),
        .ocmd_ready  (ocmd_ready),
        .icmd_op     (icmd_op),
        .icmd_period (icmd_period),
        .ocnt        (ocnt),
        .otc         (otc),
        .obusy       (obusy),
        .oerr        (oerr),
        .ostate      (ostate)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] p;
        logic [3:0] cnt;
        logic       tc;
        logic       busy;
        logic       err;
        logic [1:0] st;
        logic       rdy;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, clock one edge, sample 1 unit after the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] p);
        icmd_valid  = v;
        icmd_op     = op;
        icmd_period = p;
        @(posedge iclk);
        #1;
    endtask

    task automatic chk_all(input string name, input int cnt, input int tc, input int busy,
                           input int err, input int st, input int rdy);
        chk({name, ".cnt"},  int'(ocnt),       cnt);
        chk({name, ".tc"},   int'(otc),        tc);
        chk({name, ".busy"}, int'(obusy),      busy);
        chk({name, ".err"},  int'(oerr),       err);
        chk({name, ".st"},   int'(ostate),     st);
        chk({name, ".rdy"},  int'(ocmd_ready), rdy);
    endtask

    initial begin
        irst = 1'b1; icmd_valid = 1'b0; icmd_op = OP_STOP; icmd_period = 4'd0;

        // ONESHOT P=5, then illegal commands and a command offered while not ready
        tbl[0]  = '{1'b0, OP_STOP,     4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1};
        tbl[1]  = '{1'b1, OP_ONESHOT,  4'd5, 4'd0, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b0};
        tbl[2]  = '{1'b0, OP_STOP,     4'd0, 4'd1, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b1};
        tbl[3]  = '{1'b0, OP_STOP,     4'd0, 4'd2, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b1};
        tbl[4]  = '{1'b0, OP_STOP,     4'd0, 4'd3, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b1};
        tbl[5]  = '{1'b0, OP_STOP,     4'd0, 4'd4, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b1};
        tbl[6]  = '{1'b0, OP_STOP,     4'd0, 4'd5, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b1};
        tbl[7]  = '{1'b0, OP_STOP,     4'd0, 4'd0, 1'b1, 1'b0, 1'b0, ST_IDLE, 1'b1};
        tbl[8]  = '{1'b0, OP_STOP,     4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1};
        tbl[9]  = '{1'b1, OP_ONESHOT,  4'd0, 4'd0, 1'b0, 1'b0, 1'b1, ST_IDLE, 1'b0};
        tbl[10] = '{1'b0, OP_STOP,     4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1};
        tbl[11] = '{1'b1, OP_PAUSE,    4'd0, 4'd0, 1'b0, 1'b0, 1'b1, ST_IDLE, 1'b0};
        tbl[12] = '{1'b1, OP_ONESHOT,  4'd3, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1};
        tbl[13] = '{1'b1, OP_STOP,     4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b0};
        tbl[14] = '{1'b0, OP_STOP,     4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1};

        #50;
        chk_all("reset", 0, 0, 0, 0, ST_IDLE, 0);
        #50;
        irst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].op, tbl[i].p);
            chk_all($sformatf("tbl%0d", i), int'(tbl[i].cnt), int'(tbl[i].tc),
                    int'(tbl[i].busy), int'(tbl[i].err), int'(tbl[i].st), int'(tbl[i].rdy));
        end

        // PERIODIC P=3: otc every 4 cycles over 5 periods, then STOP
        step(1'b1, OP_PERIODIC, 4'd3);
        chk_all("per3.start", 0, 0, 1, 0, ST_RUN, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, OP_STOP, 4'd0);
            chk($sformatf("per3.c%0d.cnt", i),  int'(ocnt),   i % 4);
            chk($sformatf("per3.c%0d.tc", i),   int'(otc),    (i % 4 == 0) ? 1 : 0);
            chk($sformatf("per3.c%0d.busy", i), int'(obusy),  1);
        end
        step(1'b1, OP_STOP, 4'd0);
        chk_all("per3.stop", 0, 0, 0, 0, ST_IDLE, 0);
        step(1'b0, OP_STOP, 4'd0);

        // PERIODIC P=15, pause at 7 for 10 cycles, resume to terminal
        step(1'b1, OP_PERIODIC, 4'd15);
        for (int i = 1; i <= 7; i++) step(1'b0, OP_STOP, 4'd0);
        chk("p15.at7", int'(ocnt), 7);
        step(1'b1, OP_PAUSE, 4'd0);
        chk_all("p15.pause", 7, 0, 1, 0, ST_PAUSED, 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, OP_STOP, 4'd0);
            chk($sformatf("p15.hold%0d.cnt", i), int'(ocnt),   7);
            chk($sformatf("p15.hold%0d.st", i),  int'(ostate), int'(ST_PAUSED));
        end
        step(1'b1, OP_PAUSE, 4'd0);
        chk_all("p15.resume", 7, 0, 1, 0, ST_RUN, 0);
        for (int i = 8; i <= 15; i++) begin
            step(1'b0, OP_STOP, 4'd0);
            chk($sformatf("p15.c%0d", i), int'(ocnt), i);
            chk($sformatf("p15.c%0d.tc", i), int'(otc), 0);
        end
        step(1'b0, OP_STOP, 4'd0);
        chk_all("p15.wrap", 0, 1, 1, 0, ST_RUN, 1);
        step(1'b1, OP_STOP, 4'd0);
        step(1'b0, OP_STOP, 4'd0);

        // PERIODIC P=4, STOP on the terminal edge suppresses otc
        step(1'b1, OP_PERIODIC, 4'd4);
        for (int i = 1; i <= 4; i++) step(1'b0, OP_STOP, 4'd0);
        chk("p4.at4", int'(ocnt), 4);
        step(1'b1, OP_STOP, 4'd0);
        chk_all("p4.stop_tc", 0, 0, 0, 0, ST_IDLE, 0);
        step(1'b0, OP_STOP, 4'd0);
        chk_all("p4.after", 0, 0, 0, 0, ST_IDLE, 1);

        // restart mid-run reloads; pause on the terminal edge defers otc
        step(1'b1, OP_PERIODIC, 4'd4);
        for (int i = 1; i <= 3; i++) step(1'b0, OP_STOP, 4'd0);
        chk("rs.at3", int'(ocnt), 3);
        step(1'b1, OP_PERIODIC, 4'd2);
        chk_all("rs.reload", 0, 0, 1, 0, ST_RUN, 0);
        step(1'b0, OP_STOP, 4'd0);
        chk("rs.c1", int'(ocnt), 1);
        step(1'b0, OP_STOP, 4'd0);
        chk("rs.c2", int'(ocnt), 2);
        step(1'b1, OP_PAUSE, 4'd0);
        chk_all("rs.pause_tc", 2, 0, 1, 0, ST_PAUSED, 0);
        step(1'b0, OP_STOP, 4'd0);
        chk_all("rs.held", 2, 0, 1, 0, ST_PAUSED, 1);
        step(1'b1, OP_PAUSE, 4'd0);
        chk_all("rs.resume", 2, 0, 1, 0, ST_RUN, 0);
        step(1'b0, OP_STOP, 4'd0);
        chk_all("rs.tc", 0, 1, 1, 0, ST_RUN, 1);
        step(1'b0, OP_STOP, 4'd0);
        chk_all("rs.c1b", 1, 0, 1, 0, ST_RUN, 1);

        // asynchronous reset mid-run at ocnt=9
        step(1'b1, OP_PERIODIC, 4'd12);
        for (int i = 1; i <= 9; i++) step(1'b0, OP_STOP, 4'd0);
        chk("ar.at9", int'(ocnt), 9);
        #2 irst = 1'b1;
        #1;
        chk_all("ar.async", 0, 0, 0, 0, ST_IDLE, 0);
        @(negedge iclk);
        irst = 1'b0;
        step(1'b0, OP_STOP, 4'd0);
        chk_all("ar.release", 0, 0, 0, 0, ST_IDLE, 1);
        step(1'b0, OP_STOP, 4'd0);
        chk_all("ar.quiet", 0, 0, 0, 0, ST_IDLE, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
